uart_tx_core: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_core_if.sv | 23 ++
 rtl/uart_tx_serializer.sv | 41 ++++
 rtl/uart_tx_core.sv | 88 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width, parity-type constants and the
// transmitter state encoding. The receive path uses the same parity constants.
package uart_pkg;

    localparam int   UART_DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_core_if.sv
// Byte request handshake and per-frame line configuration between a UART
// client (master) and the transmitter core (slave).
interface uart_tx_core_if import uart_pkg::*; #(
    parameter int DATA_WIDTH  = UART_DATA_W,
    parameter int PRESC_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   DATA_VALID;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter; the core
// strobes load at acceptance and shift at the end of every data bit.
module uart_tx_serializer import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  lsb,
    output logic                  next_bit,
    output logic                  last_bit
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            shift_q   <= data;
            bit_cnt_q <= '0;
        end else if (shift) begin
            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_ONE;
        end
    end

    assign lsb      = shift_q[0];
    assign next_bit = shift_q[1];
    assign last_bit = (bit_cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: frames a byte as start, LSB-first data, optional parity
// and stop, one bit per prescale clk cycles. TX_OUT and busy are flops.
module uart_tx_core import uart_pkg::*; #(
    parameter int DATA_WIDTH  = UART_DATA_W,
    parameter int PRESC_WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_core_if.slave bus,
    output logic          TX_OUT
);
    localparam logic [PRESC_WIDTH-1:0] EDGE_ONE = PRESC_WIDTH'(1);

    tx_state_e              state_q, state_d;
    logic [PRESC_WIDTH-1:0] edge_cnt_q, presc_q;
    logic                   par_en_q, par_bit_q;
    logic                   tx_q, tx_d, busy_q, busy_d;
    logic                   accept, bit_end, shift;
    logic                   sr_lsb, sr_next, last_bit;

    assign accept  = (state_q == IDLE) && bus.DATA_VALID;
    // prescale 0 wraps to 2^PRESC_WIDTH cycles per bit through modular compare.
    assign bit_end = (edge_cnt_q == presc_q - EDGE_ONE);
    assign shift   = (state_q == DATA) && bit_end;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (shift),
        .data     (bus.P_DATA),
        .lsb      (sr_lsb),
        .next_bit (sr_next),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (state_q == IDLE || bit_end) edge_cnt_q <= '0;
            else                            edge_cnt_q <= edge_cnt_q + EDGE_ONE;
            if (accept) begin
                presc_q   <= bus.prescale;
                par_en_q  <= bus.PAR_EN;
                par_bit_q <= (^bus.P_DATA) ^ (bus.PAR_TYP == PAR_ODD);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.DATA_VALID) state_d = START;
            START:   if (bit_end)        state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end)        state_d = STOP;
            STOP:    if (bit_end)        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase

        // Line level is decoded from the next state so the output flop
        // changes on the same edge as the state register.
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift ? sr_next : sr_lsb;
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign TX_OUT   = tx_q;
    assign bus.busy = busy_q;

endmodule
